fabric_pe_load_tracked: RTL and testbench
=========================================

FABRIC_PE_LOAD_TRACKED -- requirements
Module: fabric_pe_load_tracked

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, address/data value width (>=1).
REQ-002 SHALL have parameter TAG_WIDTH, default 0, tag width (0 = untagged).
REQ-003 SHALL have parameter HW_TYPE, default 0, 0=TagOverwrite, 1=TagTransparent (requires TAG_WIDTH>0).
REQ-004 SHALL have parameter QUEUE_DEPTH, default 4, maximum outstanding memory requests (>=1).
REQ-005 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset.
REQ-006 SHALL have ports: in0_valid/in0_ready/in0_data  in/out/in  1/1/DATA_WIDTH+TAG_WIDTH  address from compute.
REQ-007 SHALL have ports: in1_valid/in1_ready/in1_data  in/out/in  1/1/DATA_WIDTH  data returned from memory, in request order.
REQ-008 SHALL have ports: in2_valid/in2_ready/in2_data  in/out/in  1/1/max(TAG_WIDTH,1)  control token.
REQ-009 SHALL have ports: out0_valid/out0_ready/out0_data  out/in/out  1/1/DATA_WIDTH+TAG_WIDTH  tagged data to compute.
REQ-010 SHALL have ports: out1_valid/out1_ready/out1_data  out/in/out  1/1/DATA_WIDTH  untagged address to memory.
REQ-011 SHALL have ports: cfg_data  in  max(TAG_WIDTH,1)  output_tag (TagOverwrite only); outstanding  out  $clog2(QUEUE_DEPTH+1)  in-flight count; err_orphan  out  1  sticky orphan-response flag.
REQ-012 SHALL use one clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-013 SHALL issue a request when in0_valid && in2_valid && !full && (HW_TYPE==0 || addr tag == ctrl tag); out1_valid equals this condition combinationally.
REQ-014 SHALL drive out1_data = in0_data[DATA_WIDTH-1:0]; in0_ready = in2_ready = out1_valid && out1_ready (issue fire).
REQ-015 SHALL, on issue fire, push into the tag queue: in0 tag (TagTransparent) or cfg_data sampled at fire (TagOverwrite); TAG_WIDTH==0 tracks count only.
REQ-016 SHALL deassert out1_valid when queue holds QUEUE_DEPTH entries, even if a pop occurs that cycle (no in1->in0_ready combinational path).
REQ-017 SHALL drive out0_valid = in1_valid && !empty; out0_data = {queue head tag, in1_data}; in1_ready = out0_ready && !empty.
REQ-018 SHALL pop the queue head on out0 fire; zero-latency pass-through from in1 to out0.
REQ-019 SHALL permit push and pop in the same cycle when 0 < count < QUEUE_DEPTH, count unchanged, tag order preserved.
REQ-020 SHALL wrap read/write pointers modulo QUEUE_DEPTH (non-power-of-two supported).
REQ-021 SHALL set err_orphan when in1_valid is high while queue empty; it stays set until reset; in1 is not consumed.
REQ-022 SHALL stall (no consume, no issue) on TagTransparent tag mismatch; no error raised.
REQ-023 SHALL report outstanding = current queue count, registered.
REQ-024 SHALL $fatal at elaboration for DATA_WIDTH<1, QUEUE_DEPTH<1, HW_TYPE not 0/1, or HW_TYPE==1 with TAG_WIDTH==0.

Reset
REQ-025 SHALL on rst_n low asynchronously clear pointers, count, err_orphan; hence out0_valid=0, out1_valid follows inputs, outstanding=0.
REQ-026 SHALL discard in-flight entries on reset mid-operation; responses arriving after reset flag err_orphan.

Structure
REQ-027 SHALL place HW_TYPE encodings (TAG_OVERWRITE=0, TAG_TRANSPARENT=1) in shared package fabric_pkg.
REQ-028 SHALL implement the tag queue as sub-module fabric_tag_fifo (WIDTH, DEPTH, push/pop, full/empty, count).

Verification
REQ-029 SHALL cover: HW_TYPE=0, TAG_WIDTH=4, cfg=0xA, issue addr 0x10, return 0x55 -> out1_data=0x10, out0_data={0xA,0x55}.
REQ-030 SHALL cover: HW_TYPE=1, issue tags 3,1,2 back-to-back, memory returns d0,d1,d2 -> out0 tags 3,1,2 in order.
REQ-031 SHALL cover: QUEUE_DEPTH=3, four requests with no response -> out1_valid low after third, outstanding=3; one return -> fourth issues next cycle.
REQ-032 SHALL cover: in1_valid with empty queue -> err_orphan=1, out0_valid=0, sticky until rst_n.
REQ-033 SHALL cover: HW_TYPE=1, addr tag 2, ctrl tag 5 -> in0_ready=in2_ready=0, out1_valid=0 until matching ctrl arrives.
REQ-034 SHALL cover: rst_n pulse with 2 outstanding -> outstanding=0, out0_valid=0 within reset, stale return sets err_orphan.

Source files
------------

// File: rtl/fabric_pkg.sv
// Shared definitions for the fabric processing-element blocks: tag-handling
// mode encodings and a width helper for optional tag fields.
package fabric_pkg;

  localparam int TAG_OVERWRITE   = 0;
  localparam int TAG_TRANSPARENT = 1;

  // Tag-carrying ports keep at least one bit even when the design is untagged.
  function automatic int tag_w1(input int tag_width);
    return (tag_width > 0) ? tag_width : 1;
  endfunction

endpackage

// File: rtl/fabric_tag_fifo.sv
// Circular tag queue with occupancy count; pointers wrap modulo DEPTH so any
// depth works. Storage is not reset, only pointers and count are.
module fabric_tag_fifo
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
)
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               head_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fabric_pe_load_tracked.sv
// Load PE: issues addresses to memory, remembers a tag per in-flight request
// and re-attaches it to the in-order memory response on the way back.
module fabric_pe_load_tracked
  import fabric_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 0,
  parameter int HW_TYPE     = 0,
  parameter int QUEUE_DEPTH = 4
)
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in0_valid,
  output logic                               in0_ready,
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0]    in0_data,
  input  logic                               in1_valid,
  output logic                               in1_ready,
  input  logic [DATA_WIDTH-1:0]              in1_data,
  input  logic                               in2_valid,
  output logic                               in2_ready,
  input  logic [tag_w1(TAG_WIDTH)-1:0]       in2_data,
  output logic                               out0_valid,
  input  logic                               out0_ready,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0]    out0_data,
  output logic                               out1_valid,
  input  logic                               out1_ready,
  output logic [DATA_WIDTH-1:0]              out1_data,
  input  logic [tag_w1(TAG_WIDTH)-1:0]       cfg_data,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   outstanding,
  output logic                               err_orphan
);

  localparam int TW1 = tag_w1(TAG_WIDTH);

  if (DATA_WIDTH < 1 || QUEUE_DEPTH < 1 ||
      (HW_TYPE != TAG_OVERWRITE && HW_TYPE != TAG_TRANSPARENT) ||
      (HW_TYPE == TAG_TRANSPARENT && TAG_WIDTH == 0)) begin : g_bad_cfg
    $fatal(1, "fabric_pe_load_tracked: illegal parameter combination");
  end

  logic [TW1-1:0] addr_tag, push_tag, head_tag;
  logic           full, empty, tag_match, issue_fire, resp_fire;
  logic           err_orphan_q, err_orphan_d;

  if (TAG_WIDTH > 0) begin : g_tagged
    assign addr_tag  = in0_data[DATA_WIDTH+TAG_WIDTH-1:DATA_WIDTH];
    assign out0_data = {head_tag, in1_data};
  end else begin : g_untagged
    logic unused_head;
    assign unused_head = ^head_tag;
    assign addr_tag    = '0;
    assign out0_data   = in1_data;
  end

  // Issue only depends on registered fullness, so a same-cycle pop cannot
  // reach in0_ready combinationally.
  assign tag_match  = (HW_TYPE == TAG_OVERWRITE) || (addr_tag == in2_data);
  assign out1_valid = in0_valid && in2_valid && !full && tag_match;
  assign out1_data  = in0_data[DATA_WIDTH-1:0];
  assign issue_fire = out1_valid && out1_ready;
  assign in0_ready  = issue_fire;
  assign in2_ready  = issue_fire;
  assign push_tag   = (HW_TYPE == TAG_TRANSPARENT) ? addr_tag : cfg_data;

  assign out0_valid = in1_valid && !empty;
  assign in1_ready  = out0_ready && !empty;
  assign resp_fire  = out0_valid && out0_ready;

  fabric_tag_fifo #(
    .WIDTH (TW1),
    .DEPTH (QUEUE_DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (issue_fire),
    .push_data_i (push_tag),
    .pop_i       (resp_fire),
    .head_o      (head_tag),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (outstanding)
  );

  // A response with nothing in flight has no tag to pair with; flag it and hold it.
  assign err_orphan_d = err_orphan_q || (in1_valid && empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_orphan_q <= 1'b0;
    else        err_orphan_q <= err_orphan_d;
  end

  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_fabric_pe_load_tracked.sv
// Bench for fabric_pe_load_tracked: a TagOverwrite unit (depth 4) and a
// TagTransparent unit (depth 3) checked against a queue-based model.
module tb_fabric_pe_load_tracked;

  logic clk = 1'b0;
  logic rst_n;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic        in0_valid;
    logic [35:0] in0_data;
    logic        in1_valid;
    logic [31:0] in1_data;
    logic        in2_valid;
    logic [3:0]  in2_data;
    logic        out0_ready;
    logic        out1_ready;
    logic [3:0]  cfg;
  } drv_t;

  typedef struct packed {
    logic        in0_ready;
    logic        in1_ready;
    logic        in2_ready;
    logic        out0_valid;
    logic [35:0] out0_data;
    logic        out1_valid;
    logic [31:0] out1_data;
    logic [2:0]  outstanding;
    logic        err;
  } obs_t;

  drv_t da, db;
  obs_t oa, ob;

  logic        a_in0_ready, a_in1_ready, a_in2_ready, a_out0_valid, a_out1_valid, a_err;
  logic [35:0] a_out0_data;
  logic [31:0] a_out1_data;
  logic [2:0]  a_outst;
  logic        b_in0_ready, b_in1_ready, b_in2_ready, b_out0_valid, b_out1_valid, b_err;
  logic [35:0] b_out0_data;
  logic [31:0] b_out1_data;
  logic [1:0]  b_outst;

  fabric_pe_load_tracked #(
    .DATA_WIDTH(32), .TAG_WIDTH(4), .HW_TYPE(0), .QUEUE_DEPTH(4)
  ) u_ovr (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(da.in0_valid), .in0_ready(a_in0_ready), .in0_data(da.in0_data),
    .in1_valid(da.in1_valid), .in1_ready(a_in1_ready), .in1_data(da.in1_data),
    .in2_valid(da.in2_valid), .in2_ready(a_in2_ready), .in2_data(da.in2_data),
    .out0_valid(a_out0_valid), .out0_ready(da.out0_ready), .out0_data(a_out0_data),
    .out1_valid(a_out1_valid), .out1_ready(da.out1_ready), .out1_data(a_out1_data),
    .cfg_data(da.cfg), .outstanding(a_outst), .err_orphan(a_err)
  );

  fabric_pe_load_tracked #(
    .DATA_WIDTH(32), .TAG_WIDTH(4), .HW_TYPE(1), .QUEUE_DEPTH(3)
  ) u_trn (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(db.in0_valid), .in0_ready(b_in0_ready), .in0_data(db.in0_data),
    .in1_valid(db.in1_valid), .in1_ready(b_in1_ready), .in1_data(db.in1_data),
    .in2_valid(db.in2_valid), .in2_ready(b_in2_ready), .in2_data(db.in2_data),
    .out0_valid(b_out0_valid), .out0_ready(db.out0_ready), .out0_data(b_out0_data),
    .out1_valid(b_out1_valid), .out1_ready(db.out1_ready), .out1_data(b_out1_data),
    .cfg_data(db.cfg), .outstanding(b_outst), .err_orphan(b_err)
  );

  assign oa = {a_in0_ready, a_in1_ready, a_in2_ready, a_out0_valid, a_out0_data,
               a_out1_valid, a_out1_data, a_outst, a_err};
  assign ob = {b_in0_ready, b_in1_ready, b_in2_ready, b_out0_valid, b_out0_data,
               b_out1_valid, b_out1_data, 1'b0, b_outst, b_err};

  // Model state: the tags of requests in flight, oldest first, and the orphan flag.
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic       ea, eb;

  function automatic logic can_issue(input int hw, input int depth, input drv_t d, input int cnt);
    return d.in0_valid && d.in2_valid && (cnt < depth) &&
           (hw == 0 || d.in0_data[35:32] == d.in2_data);
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_unit(input string u, input int hw, input int depth, input drv_t d,
                            input obs_t o, input int cnt, input logic [3:0] head, input logic err);
    logic iss;
    iss = can_issue(hw, depth, d, cnt);
    cmp({u, ".out1_valid"}, 64'(o.out1_valid), 64'(iss));
    cmp({u, ".out1_data"}, 64'(o.out1_data), 64'(d.in0_data[31:0]));
    cmp({u, ".in0_ready"}, 64'(o.in0_ready), 64'(iss && d.out1_ready));
    cmp({u, ".in2_ready"}, 64'(o.in2_ready), 64'(iss && d.out1_ready));
    cmp({u, ".out0_valid"}, 64'(o.out0_valid), 64'(d.in1_valid && cnt > 0));
    cmp({u, ".in1_ready"}, 64'(o.in1_ready), 64'(d.out0_ready && cnt > 0));
    if (d.in1_valid && cnt > 0)
      cmp({u, ".out0_data"}, 64'(o.out0_data), 64'({head, d.in1_data}));
    cmp({u, ".outstanding"}, 64'(o.outstanding), 64'(cnt));
    cmp({u, ".err_orphan"}, 64'(o.err), 64'(err));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      ea <= 1'b0;
      eb <= 1'b0;
    end else begin
      logic popa, pusha, popb, pushb;
      popa  = da.in1_valid && da.out0_ready && qa.size() > 0;
      pusha = can_issue(0, 4, da, qa.size()) && da.out1_ready;
      popb  = db.in1_valid && db.out0_ready && qb.size() > 0;
      pushb = can_issue(1, 3, db, qb.size()) && db.out1_ready;
      if (da.in1_valid && qa.size() == 0) ea <= 1'b1;
      if (db.in1_valid && qb.size() == 0) eb <= 1'b1;
      if (popa) void'(qa.pop_front());
      if (pusha) qa.push_back(da.cfg);
      if (popb) void'(qb.pop_front());
      if (pushb) qb.push_back(db.in0_data[35:32]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_unit("ovr", 0, 4, da, oa, qa.size(), (qa.size() > 0) ? qa[0] : 4'h0, ea);
      check_unit("trn", 1, 3, db, ob, qb.size(), (qb.size() > 0) ? qb[0] : 4'h0, eb);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic b_req(input logic [3:0] tag, input logic [31:0] addr);
    db.in0_valid = 1'b1;
    db.in0_data  = {tag, addr};
    db.in2_valid = 1'b1;
    db.in2_data  = tag;
  endtask

  logic [3:0]  tags30 [3] = '{4'h3, 4'h1, 4'h2};
  logic [35:0] exp30  [3] = '{36'h3_0000_00D0, 36'h1_0000_00D1, 36'h2_0000_00D2};

  initial begin
    da = '0; db = '0;
    da.out0_ready = 1'b1; da.out1_ready = 1'b1;
    db.out0_ready = 1'b1; db.out1_ready = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    cyc();
    rst_n = 1'b1;
    settle();
    cmp("reset.ovr_outstanding", 64'(a_outst), 64'd0);
    cmp("reset.trn_outstanding", 64'(b_outst), 64'd0);
    cmp("reset.ovr_out0_valid", 64'(a_out0_valid), 64'd0);
    cmp("reset.ovr_err", 64'(a_err), 64'd0);

    // TagOverwrite: address tag 7 is replaced by cfg 0xA captured at issue.
    cyc();
    da.in0_valid = 1'b1; da.in0_data = {4'h7, 32'h10};
    da.in2_valid = 1'b1; da.in2_data = 4'h0; da.cfg = 4'hA;
    settle();
    cmp("ovr.issue_valid", 64'(a_out1_valid), 64'd1);
    cmp("ovr.issue_addr", 64'(a_out1_data), 64'h10);
    cmp("ovr.issue_in0_ready", 64'(a_in0_ready), 64'd1);
    cyc();
    da.in0_valid = 1'b0; da.in2_valid = 1'b0; da.cfg = 4'h3;
    da.in1_valid = 1'b1; da.in1_data = 32'h55;
    settle();
    cmp("ovr.outstanding_1", 64'(a_outst), 64'd1);
    cmp("ovr.resp_valid", 64'(a_out0_valid), 64'd1);
    cmp("ovr.resp_data", 64'(a_out0_data), 64'hA_0000_0055);
    cyc();
    da.in1_valid = 1'b0;
    settle();
    cmp("ovr.outstanding_0", 64'(a_outst), 64'd0);

    // TagTransparent: three back-to-back issues, responses keep tag order.
    for (int i = 0; i < 3; i++) begin
      cyc();
      b_req(tags30[i], 32'h200 + 32'(i));
    end
    cyc();
    db.in0_valid = 1'b0; db.in2_valid = 1'b0;
    settle();
    cmp("trn.order_outstanding", 64'(b_outst), 64'd3);
    for (int i = 0; i < 3; i++) begin
      cyc();
      db.in1_valid = 1'b1; db.in1_data = 32'hD0 + 32'(i);
      settle();
      cmp("trn.order_data", 64'(b_out0_data), 64'(exp30[i]));
    end
    cyc();
    db.in1_valid = 1'b0;

    // Simultaneous push and pop leaves the count unchanged.
    cyc();
    b_req(4'h3, 32'h300);
    cyc();
    b_req(4'h1, 32'h301);
    db.in1_valid = 1'b1; db.in1_data = 32'hE1;
    settle();
    cmp("trn.pushpop_data", 64'(b_out0_data), 64'h3_0000_00E1);
    cmp("trn.pushpop_count", 64'(b_outst), 64'd1);
    cyc();
    db.in0_valid = 1'b0; db.in2_valid = 1'b0; db.in1_data = 32'hE2;
    settle();
    cmp("trn.pushpop_count2", 64'(b_outst), 64'd1);
    cmp("trn.pushpop_data2", 64'(b_out0_data), 64'h1_0000_00E2);
    cyc();
    db.in1_valid = 1'b0;

    // Memory backpressure blocks the handshake and the push.
    cyc();
    b_req(4'h4, 32'h340);
    db.out1_ready = 1'b0;
    settle();
    cmp("trn.bp_in0_ready", 64'(b_in0_ready), 64'd0);
    cmp("trn.bp_out1_valid", 64'(b_out1_valid), 64'd1);
    cyc();
    db.in0_valid = 1'b0; db.in2_valid = 1'b0; db.out1_ready = 1'b1;
    settle();
    cmp("trn.bp_outstanding", 64'(b_outst), 64'd0);

    // Depth 3 fills; a response in the same cycle does not reopen issue.
    for (int i = 0; i < 3; i++) begin
      cyc();
      b_req(4'h5, 32'h100 + 32'(i));
    end
    cyc();
    b_req(4'h5, 32'h103);
    settle();
    cmp("trn.full_out1_valid", 64'(b_out1_valid), 64'd0);
    cmp("trn.full_outstanding", 64'(b_outst), 64'd3);
    cyc();
    db.in1_valid = 1'b1; db.in1_data = 32'hF0;
    settle();
    cmp("trn.full_pop_out1_valid", 64'(b_out1_valid), 64'd0);
    cmp("trn.full_pop_data", 64'(b_out0_data), 64'h5_0000_00F0);
    cyc();
    db.in1_valid = 1'b0;
    settle();
    cmp("trn.fourth_valid", 64'(b_out1_valid), 64'd1);
    cmp("trn.fourth_addr", 64'(b_out1_data), 64'h103);
    cmp("trn.fourth_outstanding", 64'(b_outst), 64'd2);
    cyc();
    db.in0_valid = 1'b0; db.in2_valid = 1'b0;
    settle();
    cmp("trn.refill_outstanding", 64'(b_outst), 64'd3);
    cyc();
    db.in1_valid = 1'b1; db.in1_data = 32'hF1;
    repeat (3) cyc();
    db.in1_valid = 1'b0;
    settle();
    cmp("trn.drain_outstanding", 64'(b_outst), 64'd0);

    // Tag mismatch stalls without error until the matching control arrives.
    cyc();
    db.in0_valid = 1'b1; db.in0_data = {4'h2, 32'h400};
    db.in2_valid = 1'b1; db.in2_data = 4'h5;
    settle();
    cmp("trn.mismatch_in0_ready", 64'(b_in0_ready), 64'd0);
    cmp("trn.mismatch_in2_ready", 64'(b_in2_ready), 64'd0);
    cmp("trn.mismatch_out1_valid", 64'(b_out1_valid), 64'd0);
    cyc();
    settle();
    cmp("trn.mismatch_hold", 64'(b_out1_valid), 64'd0);
    cmp("trn.mismatch_err", 64'(b_err), 64'd0);
    cyc();
    db.in2_data = 4'h2;
    settle();
    cmp("trn.match_out1_valid", 64'(b_out1_valid), 64'd1);
    cmp("trn.match_in2_ready", 64'(b_in2_ready), 64'd1);
    cyc();
    db.in0_valid = 1'b0; db.in2_valid = 1'b0;
    db.in1_valid = 1'b1; db.in1_data = 32'h44;
    settle();
    cmp("trn.match_resp", 64'(b_out0_data), 64'h2_0000_0044);
    cyc();
    db.in1_valid = 1'b0;

    // Orphan response on the empty overwrite unit.
    cyc();
    da.in1_valid = 1'b1; da.in1_data = 32'h99;
    settle();
    cmp("ovr.orphan_out0_valid", 64'(a_out0_valid), 64'd0);
    cmp("ovr.orphan_in1_ready", 64'(a_in1_ready), 64'd0);
    cyc();
    da.in1_valid = 1'b0;
    settle();
    cmp("ovr.orphan_err", 64'(a_err), 64'd1);
    repeat (3) cyc();
    settle();
    cmp("ovr.orphan_sticky", 64'(a_err), 64'd1);

    // Reset with two requests in flight; a late response becomes an orphan.
    cyc();
    b_req(4'h1, 32'h500);
    cyc();
    b_req(4'h1, 32'h501);
    cyc();
    db.in0_valid = 1'b0; db.in2_valid = 1'b0;
    settle();
    cmp("rst.pre_outstanding", 64'(b_outst), 64'd2);
    cyc();
    rst_n = 1'b0;
    db.in1_valid = 1'b1; db.in1_data = 32'h77;
    settle();
    cmp("rst.outstanding", 64'(b_outst), 64'd0);
    cmp("rst.out0_valid", 64'(b_out0_valid), 64'd0);
    cmp("rst.in1_ready", 64'(b_in1_ready), 64'd0);
    cmp("rst.ovr_err_cleared", 64'(a_err), 64'd0);
    cyc();
    rst_n = 1'b1;
    settle();
    cmp("rst.err_before_edge", 64'(b_err), 64'd0);
    cyc();
    db.in1_valid = 1'b0;
    settle();
    cmp("rst.stale_err", 64'(b_err), 64'd1);
    cmp("rst.stale_out0_valid", 64'(b_out0_valid), 64'd0);

    cyc();
    settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
